// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory, with lock-based ownership.
// Optional round-robin contention policy: define MEM_ARBITER_ROUND_ROBIN_EN (default build is fixed priority, m0 first).
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   m0_rvalid_q, m0_rvalid_d;
  logic   m1_rvalid_q, m1_rvalid_d;
  logic   gnt0, gnt1;
  logic   hold0, hold1;
  logic   prefer0;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_q = 1 means m1 won most recently, so m0 is preferred on contention.
  logic   last_q, last_d;
  assign prefer0 = last_q;
`else
  assign prefer0 = 1'b1;
`endif

  // Ownership hold, arbitration and next-state selection.
  always_comb begin
    hold0   = 1'b0;
    hold1   = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    case (state_q)
      OWN0:    hold0 = m0_lock;
      OWN1:    hold1 = m1_lock;
      IDLE:    hold0 = 1'b0;
      default: hold0 = 1'b0;
    endcase

    if (!async_nreset) begin
      state_d = IDLE;
    end else if (hold0) begin
      gnt0    = m0_req;
      state_d = OWN0;
    end else if (hold1) begin
      gnt1    = m1_req;
      state_d = OWN1;
    end else begin
      gnt0 = m0_req & (~m1_req | prefer0);
      gnt1 = m1_req & ~gnt0;
      if (gnt0 && m0_lock) begin
        state_d = OWN0;
      end else if (gnt1 && m1_lock) begin
        state_d = OWN1;
      end else begin
        state_d = IDLE;
      end
    end

    m0_rvalid_d = gnt0 & ~m0_write;
    m1_rvalid_d = gnt1 & ~m1_write;
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Remember the most recent winner for round-robin fairness.
  always_comb begin
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end
`endif

  // Memory port mux; all-zero when nobody is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_write = m0_write;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_write = m1_write;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
    end
  end

  // State, read-return flags and last-winner register.
  always_ff @(posedge clk) begin
    if (!async_nreset) begin
      state_q     <= IDLE;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          async_nreset;
  logic          m0_req, m1_req, m0_write, m1_write, m0_lock, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];
  int checks;
  int failures;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .async_nreset(async_nreset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_write(m0_write), .m1_write(m1_write),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write on strobe, read data one cycle after address.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
    m0_lock = 1'b0; m1_lock = 1'b0;
    m0_addr = 8'h00; m1_addr = 8'h00; m0_wdata = 8'h00; m1_wdata = 8'h00;
  endtask

  task automatic test_reset();
    async_nreset = 1'b0;
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = 8'h55; m0_wdata = 8'h77;
    m1_req = 1'b1; m1_addr = 8'h66;
    cyc();
    cyc();
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m0_rvalid got=%b exp=0", m0_rvalid); end
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL reset_m1_rvalid got=%b exp=0", m1_rvalid); end
    idle_inputs();
    async_nreset = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 8'h10;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL read_m0_gnt got=%b exp=1", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL read_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL read_mem_addr got=%h exp=10", mem_addr); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL read_mem_write got=%b exp=0", mem_write); end
    cyc();
    idle_inputs();
    #1;
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL read_m0_rvalid got=%b exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 8'hA5) begin failures++; $display("FAIL read_m0_rdata got=%h exp=a5", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL read_m1_rvalid got=%b exp=0", m1_rvalid); end
    cyc();
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL read_m0_rvalid_drop got=%b exp=0", m0_rvalid); end
  endtask

  task automatic test_write();
    m1_req = 1'b1; m1_write = 1'b1; m1_addr = 8'h20; m1_wdata = 8'h3C;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL write_m1_gnt got=%b exp=1", m1_gnt); end
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL write_mem_write got=%b exp=1", mem_write); end
    checks++; if (mem_wdata !== 8'h3C) begin failures++; $display("FAIL write_mem_wdata got=%h exp=3c", mem_wdata); end
    checks++; if (mem_addr !== 8'h20) begin failures++; $display("FAIL write_mem_addr got=%h exp=20", mem_addr); end
    cyc();
    idle_inputs();
    m0_req = 1'b1; m0_addr = 8'h20;
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL write_m1_rvalid got=%b exp=0", m1_rvalid); end
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL write_rd_m0_gnt got=%b exp=1", m0_gnt); end
    cyc();
    idle_inputs();
    #1;
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL write_rd_rvalid got=%b exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 8'h3C) begin failures++; $display("FAIL write_rd_rdata got=%h exp=3c", m0_rdata); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic exp0;
    logic [7:0] exp_addr;
    async_nreset = 1'b0;
    cyc();
    async_nreset = 1'b1;
    m0_req = 1'b1; m0_addr = 8'h30;
    m1_req = 1'b1; m1_addr = 8'h31;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      exp_addr = exp0 ? 8'h30 : 8'h31;
      #1;
      checks++; if (m0_gnt !== exp0) begin failures++; $display("FAIL b2b_m0_gnt[%0d] got=%b exp=%b", i, m0_gnt, exp0); end
      checks++; if (m1_gnt !== ~exp0) begin failures++; $display("FAIL b2b_m1_gnt[%0d] got=%b exp=%b", i, m1_gnt, ~exp0); end
      checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL b2b_mem_addr[%0d] got=%h exp=%h", i, mem_addr, exp_addr); end
      cyc();
    end
    idle_inputs();
    #1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    checks++; if (m1_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_m1_rvalid got=%b exp=1", m1_rvalid); end
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_m0_rvalid got=%b exp=0", m0_rvalid); end
`else
    checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_m1_rvalid got=%b exp=0", m1_rvalid); end
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_m0_rvalid got=%b exp=1", m0_rvalid); end
`endif
    cyc();
  endtask

  task automatic test_lock();
    async_nreset = 1'b0;
    cyc();
    async_nreset = 1'b1;
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'h40;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL lock_take_m1_gnt got=%b exp=1", m1_gnt); end
    cyc();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 8'h41;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL lock_idle_owner_m0_gnt got=%b exp=0", m0_gnt); end
    cyc();
    m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL lock_hold_m0_gnt[%0d] got=%b exp=0", i, m0_gnt); end
      checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL lock_hold_m1_gnt[%0d] got=%b exp=1", i, m1_gnt); end
      cyc();
    end
    m1_lock = 1'b0;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL lock_release_m0_gnt got=%b exp=1", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL lock_release_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (mem_addr !== 8'h41) begin failures++; $display("FAIL lock_release_mem_addr got=%h exp=41", mem_addr); end
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 8'h10;
    cyc();
    m0_addr = 8'h11;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rmid_owner_m0_gnt got=%b exp=1", m0_gnt); end
    async_nreset = 1'b0;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL rmid_gnt_in_reset got=%b exp=0", m0_gnt); end
    cyc();
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_m0_rvalid got=%b exp=0", m0_rvalid); end
    async_nreset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 8'h50;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL rmid_owner_cleared_m1_gnt got=%b exp=1", m1_gnt); end
    cyc();
    m0_lock = 1'b0;
    m0_req = 1'b1;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rmid_contention_m0_gnt got=%b exp=1", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL rmid_contention_m1_gnt got=%b exp=0", m1_gnt); end
    cyc();
    idle_inputs();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    mem[8'h10] = 8'hA5;
    idle_inputs();
    async_nreset = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
